// File: rtl/div_unit_pkg.sv
// Shared CPU package: divider FSM states and iteration constants.
// Also used by the control unit for its DivCtrl wait states.
package div_unit_pkg;

  localparam int DIV_ITER  = 32;
  localparam int DIV_CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_unit.sv
// Multi-cycle signed restoring divider for DIV.
// Remainder drives HI, quotient drives LO.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  div_state_e             state_q, state_d;
  logic [DIV_CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]       rem_q, rem_d;
  logic [WIDTH-1:0]       dvd_q, dvd_d;
  logic [WIDTH-1:0]       dvs_q, dvs_d;
  logic                   sq_q, sq_d;
  logic                   sr_q, sr_d;
  logic [WIDTH-1:0]       hi_q, hi_d;
  logic [WIDTH-1:0]       lo_q, lo_d;
  logic                   done_q, done_d;
  logic                   dz_q, dz_d;

  logic [WIDTH:0]         rem_sh;
  logic [WIDTH:0]         trial;
  logic [WIDTH-1:0]       a_mag;
  logic [WIDTH-1:0]       b_mag;

  // Magnitudes are unsigned, so the most negative value maps to itself
  assign a_mag = a[WIDTH-1] ? -a : a;
  assign b_mag = b[WIDTH-1] ? -b : b;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      sq_q    <= 1'b0;
      sr_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      sq_q    <= sq_d;
      sr_q    <= sr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    sq_d    = sq_q;
    sr_d    = sr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dz_d    = 1'b0;
    rem_sh  = {rem_q, dvd_q[WIDTH-1]};
    trial   = rem_sh - {1'b0, dvs_q};
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (b == '0) begin
            dz_d = 1'b1;
          end else begin
            sq_d    = a[WIDTH-1] ^ b[WIDTH-1];
            sr_d    = a[WIDTH-1];
            dvd_d   = a_mag;
            dvs_d   = b_mag;
            rem_d   = '0;
            cnt_d   = '0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        // Dividend shifts out the top while quotient bits fill the bottom
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
        end else begin
          rem_d = rem_sh[WIDTH-1:0];
        end
        dvd_d = {dvd_q[WIDTH-2:0], ~trial[WIDTH]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == DIV_CNT_W'(DIV_ITER - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        lo_d    = sq_q ? -dvd_q : dvd_q;
        hi_d    = sr_q ? -rem_q : rem_q;
        done_d  = 1'b1;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed + randomized bench for div_unit against a
// 64-bit arithmetic reference of truncating signed division.
module tb_div_unit;

  logic        clock;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks;
  int errors;

  div_unit #(.WIDTH(32)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic void model(input logic [31:0] av,
                                input logic [31:0] bv,
                                output logic [31:0] q,
                                output logic [31:0] r);
    longint sa, sb, lq, lr;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    lq = sa / sb;
    lr = sa - lq * sb;
    q  = lq[31:0];
    r  = lr[31:0];
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Caller is at a negedge. Ends at the negedge of cycle 34.
  // rs_k > 0 pulses an extra start in that cycle with ra/rb.
  task automatic run_div(input logic [31:0] av,
                         input logic [31:0] bv,
                         input int rs_k,
                         input logic [31:0] ra,
                         input logic [31:0] rb);
    logic [31:0] eq, er;
    int bad_busy, bad_done, bad_dz, done_k;
    model(av, bv, eq, er);
    bad_busy = 0; bad_done = 0; bad_dz = 0; done_k = 0;
    start = 1'b1; a = av; b = bv;
    for (int k = 1; k <= 34; k++) begin
      @(negedge clock);
      start = 1'b0;
      a = $urandom; b = $urandom;
      if (busy !== (k <= 33)) bad_busy++;
      if (done !== (k == 34)) bad_done++;
      if (div_zero !== 1'b0) bad_dz++;
      if (done === 1'b1 && done_k == 0) done_k = k;
      if (k == rs_k) begin
        start = 1'b1; a = ra; b = rb;
      end
    end
    chk("busy_window", 32'(bad_busy), 32'd0);
    chk("done_pulse", 32'(bad_done), 32'd0);
    chk("done_cycle", 32'(done_k), 32'd34);
    chk("no_divzero", 32'(bad_dz), 32'd0);
    chk("lo", lo, eq);
    chk("hi", hi, er);
  endtask

  initial begin
    logic [31:0] ra, rb;
    checks = 0;
    errors = 0;
    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clock);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dz", 32'(div_zero), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    run_div(32'd7, 32'd2, 0, 0, 0);
    chk("t1_lo", lo, 32'h00000003);
    chk("t1_hi", hi, 32'h00000001);
    run_div(32'hFFFFFFF9, 32'd2, 0, 0, 0);
    chk("t2_lo", lo, 32'hFFFFFFFD);
    chk("t2_hi", hi, 32'hFFFFFFFF);
    run_div(32'd7, 32'hFFFFFFFE, 0, 0, 0);
    chk("t3_lo", lo, 32'hFFFFFFFD);
    chk("t3_hi", hi, 32'h00000001);

    // Divide by zero leaves hi/lo from the previous 7/2
    run_div(32'd7, 32'd2, 0, 0, 0);
    start = 1'b1; a = 32'd5; b = 32'd0;
    @(negedge clock);
    start = 1'b0;
    chk("dz_c1", 32'(div_zero), 32'd1);
    chk("dz_c1_busy", 32'(busy), 32'd0);
    chk("dz_c1_done", 32'(done), 32'd0);
    @(negedge clock);
    chk("dz_c2", 32'(div_zero), 32'd0);
    chk("dz_c2_busy", 32'(busy), 32'd0);
    chk("dz_c2_done", 32'(done), 32'd0);
    chk("dz_hi", hi, 32'd1);
    chk("dz_lo", lo, 32'd3);

    run_div(32'h80000000, 32'hFFFFFFFF, 0, 0, 0);
    chk("ovf_lo", lo, 32'h80000000);
    chk("ovf_hi", hi, 32'd0);
    run_div(32'h80000000, 32'd1, 0, 0, 0);
    chk("min1_lo", lo, 32'h80000000);
    chk("min1_hi", hi, 32'd0);

    // Second start at cycle 5 must be ignored
    run_div(32'd100, 32'd7, 5, 32'd9, 32'd3);
    chk("ign_lo", lo, 32'd14);
    chk("ign_hi", hi, 32'd2);
    @(negedge clock);
    chk("ign_idle", 32'(busy), 32'd0);

    // Reset mid-operation
    start = 1'b1; a = 32'd100; b = 32'd7;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_hi", hi, 32'd0);
    chk("mrst_lo", lo, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    run_div(32'd9, 32'd3, 0, 0, 0);
    chk("mrst_q", lo, 32'd3);
    chk("mrst_r", hi, 32'd0);

    // Back-to-back randomized operations, start in each done cycle
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 4 == 1) rb = 32'($urandom_range(1, 15));
      if (i % 4 == 2) rb = -32'($urandom_range(1, 15));
      if (i % 6 == 3) ra = 32'h80000000;
      if (rb == 32'd0) rb = 32'd1;
      run_div(ra, rb, 0, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
